itch_msg_dispatch: RTL and testbench

- Next-generation replacement for the per-type decoder test wrappers. One block frames a length-prefixed ITCH byte stream and decodes Add Order ('A'), Order Cancel ('X') and Order Delete ('D') messages.
- Decoded messages land in a unified record, buffered in a parametrised FIFO with a valid/ready output handshake.
- Sits between the byte ingress (MoldUDP-style payload, 2-byte big-endian length before each message) and the order-book logic.

---
 rtl/itch_msg_dispatch.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_itch_msg_dispatch.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itch_msg_dispatch.sv
// Frames a length-prefixed ITCH byte stream, decodes Add/Cancel/Delete messages
// into a unified record and buffers them in a valid/ready FIFO. Optional counters: ITCH_DISPATCH_STATS_EN.
module itch_msg_dispatch #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADD_LEN    = 36,
    parameter int CANCEL_LEN = 23,
    parameter int DELETE_LEN = 19
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        byte_in,
    input  logic                              valid_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [1:0]                        out_kind,
    output logic [63:0]                       out_order_ref,
    output logic                              out_side,
    output logic [31:0]                       out_shares,
    output logic [31:0]                       out_price,
    output logic [63:0]                       out_stock_symbol,
    output logic                              msg_malformed,
    output logic                              overflow_drop,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
`ifdef ITCH_DISPATCH_STATS_EN
    ,
    output logic [31:0]                       stat_add_cnt,
    output logic [31:0]                       stat_cancel_cnt,
    output logic [31:0]                       stat_delete_cnt,
    output logic [31:0]                       stat_drop_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] ST_LEN_HI = 2'd0;
    localparam logic [1:0] ST_LEN_LO = 2'd1;
    localparam logic [1:0] ST_BODY   = 2'd2;

    localparam logic [1:0] KIND_NONE   = 2'd0;
    localparam logic [1:0] KIND_ADD    = 2'd1;
    localparam logic [1:0] KIND_CANCEL = 2'd2;
    localparam logic [1:0] KIND_DELETE = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [63:0] order_ref;
        logic        side;
        logic [31:0] shares;
        logic [31:0] price;
        logic [63:0] stock;
    } rec_t;

    function automatic logic [1:0] kind_of(input logic [7:0] typ);
        logic [1:0] k;
        case (typ)
            8'h41:   k = KIND_ADD;
            8'h58:   k = KIND_CANCEL;
            8'h44:   k = KIND_DELETE;
            default: k = KIND_NONE;
        endcase
        return k;
    endfunction

    function automatic logic [15:0] len_of(input logic [1:0] kind);
        logic [15:0] l;
        case (kind)
            KIND_ADD:    l = 16'(ADD_LEN);
            KIND_CANCEL: l = 16'(CANCEL_LEN);
            KIND_DELETE: l = 16'(DELETE_LEN);
            default:     l = 16'd0;
        endcase
        return l;
    endfunction

    // framing and field state
    logic [1:0]  state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [7:0]  type_q, type_d;
    logic [63:0] ref_q, ref_d;
    logic        side_q, side_d;
    logic [31:0] shares_q, shares_d;
    logic [63:0] stock_q, stock_d;
    logic [31:0] price_q, price_d;
    logic        commit_q, commit_d;
    logic        bad_len_q, bad_len_d;
    logic        zero_len_s;
    logic [7:0]  type_now_s;

    // FIFO state
    rec_t          mem_q [FIFO_DEPTH];
    rec_t          mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    rec_t          head_q, head_d;
    logic          out_valid_q, out_valid_d;
    logic          malformed_q, malformed_d;
    logic          drop_q, drop_d;
    rec_t          new_rec_s;
    logic          pop_s, full_s, push_s, drop_s;

    // Framing FSM and by-index field capture
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        type_d     = type_q;
        ref_d      = ref_q;
        side_d     = side_q;
        shares_d   = shares_q;
        stock_d    = stock_q;
        price_d    = price_q;
        commit_d   = 1'b0;
        bad_len_d  = 1'b0;
        zero_len_s = 1'b0;
        type_now_s = (idx_q == 16'd0) ? byte_in : type_q;
        if (valid_in) begin
            case (state_q)
                ST_LEN_HI: begin
                    len_d   = {byte_in, 8'h00};
                    state_d = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    len_d = {len_q[15:8], byte_in};
                    idx_d = 16'd0;
                    if ({len_q[15:8], byte_in} == 16'd0) begin
                        zero_len_s = 1'b1;
                        state_d    = ST_LEN_HI;
                    end else begin
                        state_d = ST_BODY;
                    end
                end
                ST_BODY: begin
                    idx_d = idx_q + 16'd1;
                    // fields are cleared on the type byte so nothing stale survives
                    if (idx_q == 16'd0) begin
                        type_d   = byte_in;
                        ref_d    = 64'd0;
                        side_d   = 1'b0;
                        shares_d = 32'd0;
                        stock_d  = 64'd0;
                        price_d  = 32'd0;
                    end else if (idx_q >= 16'd11 && idx_q <= 16'd18) begin
                        ref_d = {ref_q[55:0], byte_in};
                    end else if (type_q == 8'h41 && idx_q == 16'd19) begin
                        side_d = (byte_in == 8'h53);
                    end else if (type_q == 8'h41 && idx_q >= 16'd20 && idx_q <= 16'd23) begin
                        shares_d = {shares_q[23:0], byte_in};
                    end else if (type_q == 8'h41 && idx_q >= 16'd24 && idx_q <= 16'd31) begin
                        stock_d = {stock_q[55:0], byte_in};
                    end else if (type_q == 8'h41 && idx_q >= 16'd32 && idx_q <= 16'd35) begin
                        price_d = {price_q[23:0], byte_in};
                    end else if (type_q == 8'h58 && idx_q >= 16'd19 && idx_q <= 16'd22) begin
                        shares_d = {shares_q[23:0], byte_in};
                    end else begin
                        ref_d = ref_q;
                    end
                    if (idx_q == len_q - 16'd1) begin
                        state_d = ST_LEN_HI;
                        idx_d   = 16'd0;
                        if (kind_of(type_now_s) == KIND_NONE) begin
                            commit_d = 1'b0;
                        end else if (len_q == len_of(kind_of(type_now_s))) begin
                            commit_d = 1'b1;
                        end else begin
                            bad_len_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_BODY;
                    end
                end
                default: begin
                    state_d = ST_LEN_HI;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Record assembly with per-kind zeroing of unused fields
    always_comb begin
        new_rec_s           = '0;
        new_rec_s.kind      = kind_of(type_q);
        new_rec_s.order_ref = ref_q;
        if (new_rec_s.kind == KIND_ADD) begin
            new_rec_s.side   = side_q;
            new_rec_s.shares = shares_q;
            new_rec_s.price  = price_q;
            new_rec_s.stock  = stock_q;
        end else if (new_rec_s.kind == KIND_CANCEL) begin
            new_rec_s.shares = shares_q;
        end else begin
            new_rec_s.shares = 32'd0;
        end
    end

    // FIFO control and registered head record
    always_comb begin
        pop_s       = out_valid_q & out_ready;
        full_s      = (count_q == LW'(FIFO_DEPTH));
        push_s      = commit_q & (~full_s | pop_s);
        drop_s      = commit_q & full_s & ~pop_s;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = new_rec_s;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + LW'(push_s) - LW'(pop_s);
        // a push into an otherwise-empty FIFO becomes the head directly
        if (push_s && (count_q - LW'(pop_s)) == LW'(0)) begin
            head_d = new_rec_s;
        end else if (count_d != LW'(0)) begin
            head_d = mem_q[rd_ptr_d];
        end else begin
            head_d = '0;
        end
        out_valid_d = (count_d != LW'(0));
        malformed_d = zero_len_s | bad_len_q;
        drop_d      = drop_s;
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_LEN_HI;
            len_q       <= 16'd0;
            idx_q       <= 16'd0;
            type_q      <= 8'd0;
            ref_q       <= 64'd0;
            side_q      <= 1'b0;
            shares_q    <= 32'd0;
            stock_q     <= 64'd0;
            price_q     <= 32'd0;
            commit_q    <= 1'b0;
            bad_len_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= PW'(0);
            rd_ptr_q    <= PW'(0);
            count_q     <= LW'(0);
            head_q      <= '0;
            out_valid_q <= 1'b0;
            malformed_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            type_q      <= type_d;
            ref_q       <= ref_d;
            side_q      <= side_d;
            shares_q    <= shares_d;
            stock_q     <= stock_d;
            price_q     <= price_d;
            commit_q    <= commit_d;
            bad_len_q   <= bad_len_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            out_valid_q <= out_valid_d;
            malformed_q <= malformed_d;
            drop_q      <= drop_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign out_kind         = head_q.kind;
    assign out_order_ref    = head_q.order_ref;
    assign out_side         = head_q.side;
    assign out_shares       = head_q.shares;
    assign out_price        = head_q.price;
    assign out_stock_symbol = head_q.stock;
    assign msg_malformed    = malformed_q;
    assign overflow_drop    = drop_q;
    assign fifo_level       = count_q;

`ifdef ITCH_DISPATCH_STATS_EN
    logic [31:0] add_cnt_q, add_cnt_d;
    logic [31:0] cancel_cnt_q, cancel_cnt_d;
    logic [31:0] delete_cnt_q, delete_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    // Per-kind push counters and loss counter
    always_comb begin
        add_cnt_d    = add_cnt_q + 32'(push_s && new_rec_s.kind == KIND_ADD);
        cancel_cnt_d = cancel_cnt_q + 32'(push_s && new_rec_s.kind == KIND_CANCEL);
        delete_cnt_d = delete_cnt_q + 32'(push_s && new_rec_s.kind == KIND_DELETE);
        drop_cnt_d   = drop_cnt_q + 32'(drop_s) + 32'(malformed_d);
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            add_cnt_q    <= 32'd0;
            cancel_cnt_q <= 32'd0;
            delete_cnt_q <= 32'd0;
            drop_cnt_q   <= 32'd0;
        end else begin
            add_cnt_q    <= add_cnt_d;
            cancel_cnt_q <= cancel_cnt_d;
            delete_cnt_q <= delete_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign stat_add_cnt    = add_cnt_q;
    assign stat_cancel_cnt = cancel_cnt_q;
    assign stat_delete_cnt = delete_cnt_q;
    assign stat_drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_itch_msg_dispatch.sv
// Directed, table-driven bench for itch_msg_dispatch plus hand sequences for
// latency, back-to-back framing, backpressure/overflow, zero length and mid-message reset.
module tb_itch_msg_dispatch;

    typedef struct packed {
        logic [1:0]  kind;
        logic [63:0] oref;
        logic        side;
        logic [31:0] shares;
        logic [31:0] price;
        logic [63:0] stock;
    } trec_t;

    typedef struct {
        logic [15:0] len;
        logic [7:0]  typ;
        logic [63:0] oref;
        logic [7:0]  side;
        logic [31:0] shares;
        logic [63:0] stock;
        logic [31:0] price;
        int          exp_recs;
        trec_t       exp;
        int          exp_mal;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        valid_in;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [63:0] out_order_ref;
    logic        out_side;
    logic [31:0] out_shares;
    logic [31:0] out_price;
    logic [63:0] out_stock_symbol;
    logic        msg_malformed;
    logic        overflow_drop;
    logic [2:0]  fifo_level;
`ifdef ITCH_DISPATCH_STATS_EN
    logic [31:0] stat_add_cnt, stat_cancel_cnt, stat_delete_cnt, stat_drop_cnt;
`endif

    itch_msg_dispatch #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .valid_in(valid_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_order_ref(out_order_ref), .out_side(out_side), .out_shares(out_shares),
        .out_price(out_price), .out_stock_symbol(out_stock_symbol),
        .msg_malformed(msg_malformed), .overflow_drop(overflow_drop), .fifo_level(fifo_level)
`ifdef ITCH_DISPATCH_STATS_EN
        , .stat_add_cnt(stat_add_cnt), .stat_cancel_cnt(stat_cancel_cnt),
        .stat_delete_cnt(stat_delete_cnt), .stat_drop_cnt(stat_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    int    mal_cnt = 0;
    int    ovf_cnt = 0;
    bit    stall_en = 1'b0;
    trec_t recq[$];

    // Observe handshakes and pulses half a cycle away from the active edge
    always @(negedge clk) begin
        if (out_valid && out_ready)
            recq.push_back({out_kind, out_order_ref, out_side, out_shares, out_price, out_stock_symbol});
        if (msg_malformed) mal_cnt++;
        if (overflow_drop) ovf_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        if (stall_en) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
                valid_in = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        byte_in  = b;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input logic [15:0] len, input logic [7:0] typ, input logic [63:0] oref,
                            input logic [7:0] side, input logic [31:0] shares,
                            input logic [63:0] stock, input logic [31:0] price, input int nbody);
        logic [7:0] b [0:63];
        for (int i = 0; i < 64; i++) b[i] = 8'hA0 + 8'(i);
        b[0] = typ;
        for (int i = 0; i < 8; i++) b[11+i] = oref[63-8*i -: 8];
        if (typ == 8'h41) begin
            b[19] = side;
            for (int i = 0; i < 4; i++) b[20+i] = shares[31-8*i -: 8];
            for (int i = 0; i < 8; i++) b[24+i] = stock[63-8*i -: 8];
            for (int i = 0; i < 4; i++) b[32+i] = price[31-8*i -: 8];
        end else if (typ == 8'h58) begin
            for (int i = 0; i < 4; i++) b[19+i] = shares[31-8*i -: 8];
        end
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        for (int i = 0; i < nbody; i++) send_byte(b[i]);
    endtask

    function automatic trec_t mk_rec(input logic [1:0] k, input logic [63:0] r, input logic s,
                                     input logic [31:0] sh, input logic [31:0] p, input logic [63:0] st);
        trec_t t;
        t.kind = k; t.oref = r; t.side = s; t.shares = sh; t.price = p; t.stock = st;
        return t;
    endfunction

    function automatic vec_t mk_vec(input logic [15:0] len, input logic [7:0] typ, input logic [63:0] r,
                                    input logic [7:0] s, input logic [31:0] sh, input logic [63:0] st,
                                    input logic [31:0] p, input int nrec, input trec_t e, input int nmal);
        vec_t v;
        v.len = len; v.typ = typ; v.oref = r; v.side = s; v.shares = sh; v.stock = st; v.price = p;
        v.exp_recs = nrec; v.exp = e; v.exp_mal = nmal;
        return v;
    endfunction

    vec_t  vecs [8];
    trec_t got;
    logic [255:0] refs;

    initial begin
        vecs[0] = mk_vec(16'd36, 8'h41, 64'h1234, 8'h42, 32'd100, 64'h4141504C20202020, 32'd1500000, 1,
                         mk_rec(2'd1, 64'h1234, 1'b0, 32'd100, 32'd1500000, 64'h4141504C20202020), 0);
        vecs[1] = mk_vec(16'd36, 8'h41, 64'hDEADBEEF01020304, 8'h53, 32'h01020304, 64'h4D53465420202020,
                         32'h0A0B0C0D, 1,
                         mk_rec(2'd1, 64'hDEADBEEF01020304, 1'b1, 32'h01020304, 32'h0A0B0C0D,
                                64'h4D53465420202020), 0);
        vecs[2] = mk_vec(16'd23, 8'h58, 64'h55, 8'h53, 32'd40, 64'hFFFF, 32'hFFFF, 1,
                         mk_rec(2'd2, 64'h55, 1'b0, 32'd40, 32'd0, 64'd0), 0);
        vecs[3] = mk_vec(16'd19, 8'h44, 64'h66, 8'h53, 32'd9, 64'hFFFF, 32'hFFFF, 1,
                         mk_rec(2'd3, 64'h66, 1'b0, 32'd0, 32'd0, 64'd0), 0);
        vecs[4] = mk_vec(16'd31, 8'h45, 64'h77, 8'h00, 32'd0, 64'd0, 32'd0, 0, '0, 0);
        vecs[5] = mk_vec(16'd30, 8'h41, 64'h78, 8'h42, 32'd5, 64'd0, 32'd0, 0, '0, 1);
        vecs[6] = mk_vec(16'd24, 8'h58, 64'h79, 8'h00, 32'd5, 64'd0, 32'd0, 0, '0, 1);
        vecs[7] = mk_vec(16'd18, 8'h44, 64'h7A, 8'h00, 32'd0, 64'd0, 32'd0, 0, '0, 1);

        rst = 1'b0; byte_in = 8'h00; valid_in = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              256'({out_valid, out_kind, out_order_ref, out_side, out_shares, out_price,
                    out_stock_symbol, msg_malformed, overflow_drop, fifo_level}), 256'd0);
        rst = 1'b1;
        idle(2);

        // Table: each vector sent alone, first without then with input stalls
        out_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            stall_en = (pass == 1);
            for (int v = 0; v < 8; v++) begin
                recq.delete();
                mal_cnt = 0;
                send_msg(vecs[v].len, vecs[v].typ, vecs[v].oref, vecs[v].side, vecs[v].shares,
                         vecs[v].stock, vecs[v].price, int'(vecs[v].len));
                idle(6);
                check($sformatf("vec%0d_p%0d_count", v, pass), 256'(recq.size()), 256'(vecs[v].exp_recs));
                check($sformatf("vec%0d_p%0d_malformed", v, pass), 256'(mal_cnt), 256'(vecs[v].exp_mal));
                if (vecs[v].exp_recs > 0) begin
                    got = (recq.size() > 0) ? recq[0] : '0;
                    check($sformatf("vec%0d_p%0d_record", v, pass), 256'(got), 256'(vecs[v].exp));
                end
            end
        end
        stall_en = 1'b0;

        // Latency: record appears one edge after the last body byte
        out_ready = 1'b0;
        send_msg(16'd36, 8'h41, 64'h1234, 8'h42, 32'd100, 64'h4141504C20202020, 32'd1500000, 36);
        valid_in = 1'b0;
        check("latency_edgeN_valid", 256'(out_valid), 256'd0);
        @(posedge clk);
        #1;
        check("latency_edgeN1_valid", 256'(out_valid), 256'd1);
        check("latency_level", 256'(fifo_level), 256'd1);
        check("latency_head_price", 256'(out_price), 256'd1500000);
        recq.delete();
        out_ready = 1'b1;
        idle(3);
        check("latency_drain_level", 256'(fifo_level), 256'd0);

        // Back-to-back cancel then delete, then unknown then delete
        for (int pass = 0; pass < 2; pass++) begin
            stall_en = (pass == 1);
            recq.delete();
            mal_cnt = 0;
            send_msg(16'd23, 8'h58, 64'h55, 8'h00, 32'd40, 64'd0, 32'd0, 23);
            send_msg(16'd19, 8'h44, 64'h66, 8'h00, 32'd0, 64'd0, 32'd0, 19);
            send_msg(16'd31, 8'h45, 64'h99, 8'h00, 32'd0, 64'd0, 32'd0, 31);
            send_msg(16'd19, 8'h44, 64'h67, 8'h00, 32'd0, 64'd0, 32'd0, 19);
            idle(6);
            check($sformatf("b2b_p%0d_count", pass), 256'(recq.size()), 256'd3);
            check($sformatf("b2b_p%0d_malformed", pass), 256'(mal_cnt), 256'd0);
            if (recq.size() == 3) begin
                check($sformatf("b2b_p%0d_rec0", pass), 256'(recq[0]),
                      256'(mk_rec(2'd2, 64'h55, 1'b0, 32'd40, 32'd0, 64'd0)));
                check($sformatf("b2b_p%0d_rec1", pass), 256'(recq[1]),
                      256'(mk_rec(2'd3, 64'h66, 1'b0, 32'd0, 32'd0, 64'd0)));
                check($sformatf("b2b_p%0d_rec2", pass), 256'(recq[2]),
                      256'(mk_rec(2'd3, 64'h67, 1'b0, 32'd0, 32'd0, 64'd0)));
            end
        end
        stall_en = 1'b0;

        // Zero length frame followed by a delete
        recq.delete();
        mal_cnt = 0;
        send_byte(8'h00);
        send_byte(8'h00);
        send_msg(16'd19, 8'h44, 64'h9A, 8'h00, 32'd0, 64'd0, 32'd0, 19);
        idle(6);
        check("zero_len_malformed", 256'(mal_cnt), 256'd1);
        check("zero_len_count", 256'(recq.size()), 256'd1);
        check("zero_len_ref", 256'((recq.size() > 0) ? recq[0].oref : 64'd0), 256'h9A);

        // Backpressure: six deletes into a four-deep FIFO
        out_ready = 1'b0;
        recq.delete();
        ovf_cnt = 0;
        for (int i = 1; i <= 6; i++)
            send_msg(16'd19, 8'h44, 64'(i), 8'h00, 32'd0, 64'd0, 32'd0, 19);
        idle(4);
        check("bp_level_full", 256'(fifo_level), 256'd4);
        check("bp_overflow_pulses", 256'(ovf_cnt), 256'd2);
        check("bp_head_ref", 256'(out_order_ref), 256'd1);
        out_ready = 1'b1;
        idle(8);
        check("bp_drain_count", 256'(recq.size()), 256'd4);
        refs = '0;
        for (int i = 0; i < recq.size() && i < 4; i++) refs[64*i +: 64] = recq[i].oref;
        check("bp_drain_order", refs, {64'd4, 64'd3, 64'd2, 64'd1});
        check("bp_level_empty", 256'(fifo_level), 256'd0);

        // Async reset in the middle of an add body, with a record queued
        out_ready = 1'b0;
        send_msg(16'd19, 8'h44, 64'h77, 8'h00, 32'd0, 64'd0, 32'd0, 19);
        idle(3);
        check("rst_pre_level", 256'(fifo_level), 256'd1);
        send_msg(16'd36, 8'h41, 64'hABCD, 8'h53, 32'd7, 64'h1111, 32'd9, 16);
        valid_in = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_level", 256'(fifo_level), 256'd0);
        check("rst_mid_valid", 256'({out_valid, out_kind, out_order_ref}), 256'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        idle(1);
        recq.delete();
        mal_cnt = 0;
        out_ready = 1'b1;
        send_msg(16'd19, 8'h44, 64'h88, 8'h00, 32'd0, 64'd0, 32'd0, 19);
        idle(6);
        check("rst_post_count", 256'(recq.size()), 256'd1);
        check("rst_post_rec", 256'((recq.size() > 0) ? recq[0] : '0),
              256'(mk_rec(2'd3, 64'h88, 1'b0, 32'd0, 32'd0, 64'd0)));
        check("rst_post_malformed", 256'(mal_cnt), 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
